// File: rtl/mmio_responder_if.sv
// CPU data-port view of the MMIO register window: store/load strobes in, load data and window hit out.
interface mmio_responder_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic              mem_write;
   logic [1:0]        swhb;
   logic [1:0]        lwhb;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              hit;

   modport master (
      output mem_write, swhb, lwhb, addr, wdata,
      input  rdata, hit
   );

   modport slave (
      input  mem_write, swhb, lwhb, addr, wdata,
      output rdata, hit
   );
endinterface

// File: rtl/mmio_responder.sv
// Board peripheral registers (switches, 7-seg, debounced button, timer with compare IRQ)
// mapped into a 32-byte window on the CPU data port.
module mmio_responder #(
   parameter int unsigned       ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(10'h3E0),
   parameter logic [19:0]       DB_CYCLES = 20'd50000
) (
   input  logic               clk,
   input  logic               rstn,
   mmio_responder_if.slave    bus,
   input  logic [15:0]        sw_i,
   input  logic               btn_i,
   output logic [31:0]        seg_data,
   output logic               irq
);
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SW_W    = 16;
   localparam int unsigned DB_W    = 20;
   localparam int unsigned WIN_LSB = 5;

   localparam logic [2:0] REG_SW   = 3'd0;
   localparam logic [2:0] REG_SEG  = 3'd1;
   localparam logic [2:0] REG_BTN  = 3'd2;
   localparam logic [2:0] REG_CNT  = 3'd3;
   localparam logic [2:0] REG_CMP  = 3'd4;
   localparam logic [2:0] REG_CTRL = 3'd5;

   logic [SW_W-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic              btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic              db_lvl_q, db_lvl_d, db_prev_q, db_prev_d;
   logic              press_q, press_d;
   logic [DATA_W-1:0] seg_q, seg_d, cnt_q, cnt_d, cmp_q, cmp_d;
   logic              match_q, match_d, irq_en_q, irq_en_d;

   logic [2:0]        reg_sel;
   logic [1:0]        bsel;
   logic [3:0]        wr_mask;
   logic [DATA_W-1:0] wr_rep, bit_mask;
   logic              wr_go;
   logic [DATA_W-1:0] rd_word, rd_shift, rdata_c;

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] rep,
                                               input logic [DATA_W-1:0] bm);
      return (old & ~bm) | (rep & bm);
   endfunction

   assign reg_sel  = bus.addr[4:2];
   assign bsel     = bus.addr[1:0];
   assign bus.hit  = (bus.addr[ADDR_W-1:WIN_LSB] == BASE[ADDR_W-1:WIN_LSB]);
   assign bus.rdata = rdata_c;
   assign seg_data = seg_q;
   assign irq      = match_q & irq_en_q;

   // Store lane mask; misaligned halves/words and swhb=11 leave the mask empty.
   always_comb begin
      wr_mask = 4'b0000;
      wr_rep  = bus.wdata;
      case (bus.swhb)
         2'b10: begin
            wr_mask = 4'b0001 << bsel;
            wr_rep  = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            if (!bsel[0]) wr_mask = bsel[1] ? 4'b1100 : 4'b0011;
            wr_rep = {2{bus.wdata[15:0]}};
         end
         2'b00: begin
            if (bsel == 2'b00) wr_mask = 4'b1111;
         end
         default: wr_mask = 4'b0000;
      endcase
      bit_mask = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};
      wr_go    = bus.mem_write & bus.hit & (wr_mask != 4'b0000);
   end

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         REG_SW:   rd_word = {16'h0, sw_s2_q};
         REG_SEG:  rd_word = seg_q;
         REG_BTN:  rd_word = {30'h0, db_lvl_q, press_q};
         REG_CNT:  rd_word = cnt_q;
         REG_CMP:  rd_word = cmp_q;
         REG_CTRL: rd_word = {30'h0, irq_en_q, match_q};
         default:  rd_word = '0;
      endcase
      rd_shift = rd_word >> {bsel, 3'b000};
      rdata_c  = '0;
      case (bus.lwhb)
         2'b10:   rdata_c = {24'h0, rd_shift[7:0]};
         2'b01:   rdata_c = bsel[0] ? '0 : {16'h0, rd_shift[15:0]};
         default: rdata_c = (bsel != 2'b00) ? '0 : rd_word;
      endcase
      if (!bus.hit) rdata_c = '0;
   end

   always_comb begin
      sw_s1_d   = sw_i;
      sw_s2_d   = sw_s1_q;
      btn_s1_d  = btn_i;
      btn_s2_d  = btn_s1_q;
      db_cnt_d  = db_cnt_q;
      db_lvl_d  = db_lvl_q;
      db_prev_d = db_lvl_q;
      press_d   = press_q;
      seg_d     = seg_q;
      cnt_d     = cnt_q + 32'd1;
      cmp_d     = cmp_q;
      match_d   = match_q;
      irq_en_d  = irq_en_q;

      // A bounce back to the debounced level restarts the stability count.
      if (btn_s2_q == db_lvl_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_CYCLES - 20'd1) begin
         db_lvl_d = btn_s2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 20'd1;
      end

      if (wr_go) begin
         case (reg_sel)
            REG_SEG:  seg_d = merge(seg_q, wr_rep, bit_mask);
            REG_CNT:  cnt_d = merge(cnt_q, wr_rep, bit_mask);
            REG_CMP:  cmp_d = merge(cmp_q, wr_rep, bit_mask);
            REG_BTN:  if (bit_mask[0] & wr_rep[0]) press_d = 1'b0;
            REG_CTRL: begin
               if (bit_mask[0] & wr_rep[0]) match_d = 1'b0;
               if (bit_mask[1]) irq_en_d = wr_rep[1];
            end
            default: ;
         endcase
      end

      // Sticky flags: a set in the same cycle as a clear wins.
      if (db_lvl_q & ~db_prev_q) press_d = 1'b1;
      if (cnt_q == cmp_q) match_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         btn_s1_q  <= 1'b0;
         btn_s2_q  <= 1'b0;
         db_cnt_q  <= '0;
         db_lvl_q  <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
         seg_q     <= '0;
         cnt_q     <= '0;
         cmp_q     <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         irq_en_q  <= 1'b0;
      end else begin
         sw_s1_q   <= sw_s1_d;
         sw_s2_q   <= sw_s2_d;
         btn_s1_q  <= btn_s1_d;
         btn_s2_q  <= btn_s2_d;
         db_cnt_q  <= db_cnt_d;
         db_lvl_q  <= db_lvl_d;
         db_prev_q <= db_prev_d;
         press_q   <= press_d;
         seg_q     <= seg_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         match_q   <= match_d;
         irq_en_q  <= irq_en_d;
      end
   end
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register map, lane handling, debounce, timer match and wrap.
module tb_mmio_responder;
   localparam int unsigned ADDR_W = 10;
   localparam logic [9:0]  BASE   = 10'h3E0;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] sw_i = 16'h0;
   logic        btn_i = 1'b0;
   logic [31:0] seg_data;
   logic        irq;
   int          checks = 0;
   int          errors = 0;

   mmio_responder_if #(.ADDR_W(ADDR_W)) bus ();

   mmio_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .DB_CYCLES(20'd16)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .sw_i(sw_i), .btn_i(btn_i),
      .seg_data(seg_data), .irq(irq)
   );

   always #5 clk = ~clk;

   // Store takes effect on the next rising edge; returns 1ns after it.
   task automatic store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
      bus.addr = a; bus.swhb = sz; bus.wdata = d; bus.mem_write = 1'b1;
      @(posedge clk); #1;
      bus.mem_write = 1'b0; bus.swhb = 2'b11;
   endtask

   task automatic look(input logic [9:0] a, input logic [1:0] sz);
      bus.addr = a; bus.lwhb = sz; #1;
   endtask

   task automatic test_reset;
      #12;
      look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp %h", bus.rdata, 32'h0); end
      look(10'h3F0, 2'b00);
      checks++; if (bus.rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_cmp got %h exp %h", bus.rdata, 32'hFFFFFFFF); end
      checks++; if (seg_data !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL rst_outs got seg=%h irq=%b exp 0/0", seg_data, irq); end
      // The edge that releases reset counts as post-reset cycle 1; after 8 cycles CNT reads 7.
      @(posedge clk); #1 rstn = 1'b1;
      repeat (7) @(posedge clk);
      #1 look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'd7) begin errors++; $display("FAIL cnt_after_8 got %h exp %h", bus.rdata, 32'd7); end
      checks++; if (seg_data !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL post_rst_outs got seg=%h irq=%b exp 0/0", seg_data, irq); end
      look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_btn got %h exp %h", bus.rdata, 32'h0); end
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", bus.rdata, 32'h0); end
   endtask

   task automatic test_hit;
      logic [9:0] hit_addr [4];
      logic       hit_exp [4];
      hit_addr = '{10'h3E0, 10'h3FF, 10'h3DF, 10'h3C0};
      hit_exp  = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         look(hit_addr[i], 2'b00);
         checks++; if (bus.hit !== hit_exp[i]) begin errors++; $display("FAIL hit_%h got %b exp %b", hit_addr[i], bus.hit, hit_exp[i]); end
      end
   endtask

   task automatic test_sw;
      sw_i = 16'hBEEF;
      @(posedge clk); #1 look(10'h3E0, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL sw_lat1 got %h exp %h", bus.rdata, 32'h0); end
      @(posedge clk); #1 look(10'h3E0, 2'b00);
      checks++; if (bus.rdata !== 32'h0000BEEF) begin errors++; $display("FAIL sw_lat2 got %h exp %h", bus.rdata, 32'h0000BEEF); end
      look(10'h3E1, 2'b10);
      checks++; if (bus.rdata !== 32'hBE) begin errors++; $display("FAIL sw_byte1 got %h exp %h", bus.rdata, 32'hBE); end
      look(10'h3E1, 2'b01);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL sw_half_mis got %h exp %h", bus.rdata, 32'h0); end
   endtask

   task automatic test_seg;
      store(10'h3E5, 2'b10, 32'hFFFF_FFA5);
      checks++; if (seg_data !== 32'h0000A500) begin errors++; $display("FAIL seg_byte got %h exp %h", seg_data, 32'h0000A500); end
      store(10'h3E6, 2'b01, 32'hFFFF_1234);
      checks++; if (seg_data !== 32'h1234A500) begin errors++; $display("FAIL seg_half got %h exp %h", seg_data, 32'h1234A500); end
      store(10'h3E5, 2'b01, 32'hFFFF_FFFF);
      store(10'h3E6, 2'b00, 32'hFFFF_FFFF);
      store(10'h3E4, 2'b11, 32'hFFFF_FFFF);
      checks++; if (seg_data !== 32'h1234A500) begin errors++; $display("FAIL seg_dropped got %h exp %h", seg_data, 32'h1234A500); end
      look(10'h3E7, 2'b10);
      checks++; if (bus.rdata !== 32'h12) begin errors++; $display("FAIL seg_ld_byte got %h exp %h", bus.rdata, 32'h12); end
      look(10'h3E6, 2'b01);
      checks++; if (bus.rdata !== 32'h1234) begin errors++; $display("FAIL seg_ld_half got %h exp %h", bus.rdata, 32'h1234); end
      look(10'h3E4, 2'b11);
      checks++; if (bus.rdata !== 32'h1234A500) begin errors++; $display("FAIL seg_ld_word got %h exp %h", bus.rdata, 32'h1234A500); end
      look(10'h3E5, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL seg_ld_mis got %h exp %h", bus.rdata, 32'h0); end
   endtask

   task automatic test_btn;
      int bad = 0;
      int presses = 0;
      logic prev = 1'b0;
      // Five toggles 7 cycles apart (shorter than the 16-cycle window), ending high.
      for (int i = 0; i < 5; i++) begin
         btn_i = ~btn_i;
         repeat (7) begin
            @(posedge clk); #1 look(10'h3E8, 2'b00);
            if (bus.rdata !== 32'h0) bad++;
            if (bus.rdata[0] & ~prev) presses++;
            prev = bus.rdata[0];
         end
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL btn_bounce got %0d nonzero reads exp 0", bad); end
      repeat (30) begin
         @(posedge clk); #1 look(10'h3E8, 2'b00);
         if (bus.rdata[0] & ~prev) presses++;
         prev = bus.rdata[0];
      end
      checks++; if (presses !== 1) begin errors++; $display("FAIL btn_presses got %0d exp 1", presses); end
      checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL btn_settled got %h exp %h", bus.rdata, 32'h3); end
      store(10'h3E8, 2'b00, 32'h1);
      look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h2) begin errors++; $display("FAIL btn_w1c got %h exp %h", bus.rdata, 32'h2); end
      repeat (20) @(posedge clk);
      #1 look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h2) begin errors++; $display("FAIL btn_no_repress got %h exp %h", bus.rdata, 32'h2); end
      btn_i = 1'b0;
      repeat (25) @(posedge clk);
      #1 look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL btn_release got %h exp %h", bus.rdata, 32'h0); end
   endtask

   task automatic test_timer;
      store(10'h3F0, 2'b00, 32'd10);
      store(10'h3F4, 2'b00, 32'h2);
      store(10'h3EC, 2'b00, 32'h0);
      look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL cnt_load got %h exp %h", bus.rdata, 32'h0); end
      // CNT reaches 10 after 10 edges; the flag sets on the following edge.
      repeat (10) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_match got %b exp 1", irq); end
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL ctrl_match got %h exp %h", bus.rdata, 32'h3); end
      store(10'h3F4, 2'b00, 32'h3);
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h2 || irq !== 1'b0) begin errors++; $display("FAIL ctrl_w1c got %h irq=%b exp 2/0", bus.rdata, irq); end
      // Clear lands on the same edge as the next match: the set must win.
      store(10'h3EC, 2'b00, 32'd5);
      repeat (5) @(posedge clk);
      #1 store(10'h3F4, 2'b00, 32'h3);
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h3 || irq !== 1'b1) begin errors++; $display("FAIL ctrl_set_wins got %h irq=%b exp 3/1", bus.rdata, irq); end
      store(10'h3F4, 2'b00, 32'h3);
      store(10'h3F0, 2'b00, 32'h100);
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h2) begin errors++; $display("FAIL ctrl_w1c2 got %h exp %h", bus.rdata, 32'h2); end
      store(10'h3F7, 2'b10, 32'hFF);
      look(10'h3F4, 2'b00);
      checks++; if (bus.rdata !== 32'h2) begin errors++; $display("FAIL ctrl_hi_ignored got %h exp %h", bus.rdata, 32'h2); end
   endtask

   task automatic test_wrap;
      store(10'h3EC, 2'b00, 32'hFFFFFFFE);
      look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap0 got %h exp %h", bus.rdata, 32'hFFFFFFFE); end
      @(posedge clk); #1 look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap1 got %h exp %h", bus.rdata, 32'hFFFFFFFF); end
      @(posedge clk); #1 look(10'h3EC, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL wrap2 got %h exp %h", bus.rdata, 32'h0); end
      store(10'h3FC, 2'b00, 32'hDEADBEEF);
      look(10'h3FC, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rsvd_read got %h exp %h", bus.rdata, 32'h0); end
      store(10'h3C4, 2'b00, 32'hDEADBEEF);
      store(10'h3C0, 2'b00, 32'hDEADBEEF);
      look(10'h3C0, 2'b00);
      checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", bus.hit); end
      checks++; if (seg_data !== 32'h1234A500) begin errors++; $display("FAIL miss_seg got %h exp %h", seg_data, 32'h1234A500); end
      look(10'h3F0, 2'b00);
      checks++; if (bus.rdata !== 32'h100) begin errors++; $display("FAIL miss_cmp got %h exp %h", bus.rdata, 32'h100); end
   endtask

   task automatic test_rst_debounce;
      btn_i = 1'b1;
      repeat (12) @(posedge clk);
      #1 rstn = 1'b0;
      #1 look(10'h3F0, 2'b00);
      checks++; if (seg_data !== 32'h0 || irq !== 1'b0 || bus.rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL in_reset got seg=%h irq=%b cmp=%h exp 0/0/ffffffff", seg_data, irq, bus.rdata); end
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (10) @(posedge clk);
      #1 look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL db_restart got %h exp %h", bus.rdata, 32'h0); end
      repeat (30) @(posedge clk);
      #1 look(10'h3E8, 2'b00);
      checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL db_after_rst got %h exp %h", bus.rdata, 32'h3); end
   endtask

   initial begin
      bus.mem_write = 1'b0;
      bus.swhb      = 2'b11;
      bus.lwhb      = 2'b00;
      bus.addr      = '0;
      bus.wdata     = '0;
      test_reset();
      test_hit();
      test_sw();
      test_seg();
      test_btn();
      test_timer();
      test_wrap();
      test_rst_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
